global_history_register: RTL and testbench

Speculative global branch-history register for the tournament predictor. Sits directly upstream of the global-history predictor: it supplies the speculative history that indexes the pattern table at fetch, and on resolution it returns the exact history each branch was predicted with, so the table updates the correct counter. An in-order checkpoint FIFO holds the pre-shift history of every in-flight branch so a mispredict repairs the history in one cycle.

---
 rtl/ghr_pkg.sv | 15 +
 rtl/ghr_checkpoint_fifo.sv | 54 +++++
 rtl/global_history_register.sv | 103 ++++++++++
 tb/tb_global_history_register.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ghr_pkg.sv
// Shared types for the speculative global branch-history register.
// Provides the default history width and the checkpoint entry layout.
package ghr_pkg;

    localparam int HIST_W_DEFAULT = 12;

    typedef logic [HIST_W_DEFAULT-1:0] history_t;

    // One in-flight branch: history it was predicted with, plus its prediction.
    typedef struct packed {
        history_t hist;
        logic     pred;
    } checkpoint_t;

endpackage

// File: rtl/ghr_checkpoint_fifo.sv
// In-order checkpoint FIFO holding one entry per unresolved branch.
// Ports: clock/reset, push+push_data, pop, flush, head_data, count, full, empty.
module ghr_checkpoint_fifo
    import ghr_pkg::*;
#(
    parameter type entry_t = checkpoint_t,
    parameter int  DEPTH   = 8,
    localparam int PW      = $clog2(DEPTH),
    localparam int CW      = PW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    input  logic          flush,
    output entry_t        head_data,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    entry_t          mem [DEPTH];
    logic   [PW-1:0] head;
    logic   [PW-1:0] tail;

    // Storage needs no reset; pointers and count define validity.
    always_ff @(posedge clock) begin
        if (push && !flush) begin
            mem[tail] <= push_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            if (push) begin
                tail <= tail + PW'(1);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign head_data = mem[head];
    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);

endmodule

// File: rtl/global_history_register.sv
// Speculative global history with checkpointed one-cycle mispredict repair.
// Ports: fetch side (valid/taken_pred/ready, global_history), resolve side
// (valid/taken), registered predictor update (upd_*), retired history,
// inflight_count and a resolve_error pulse for resolves with nothing in flight.
module global_history_register
    import ghr_pkg::*;
#(
    parameter int  HIST_W = HIST_W_DEFAULT,
    parameter int  DEPTH  = 8,
    localparam int CW     = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              fetch_valid,
    input  logic              fetch_taken_pred,
    output logic              fetch_ready,
    output logic [HIST_W-1:0] global_history,
    input  logic              resolve_valid,
    input  logic              resolve_taken,
    output logic              upd_valid,
    output logic [HIST_W-1:0] upd_history,
    output logic              upd_taken,
    output logic              upd_mispredict,
    output logic [HIST_W-1:0] retired_history,
    output logic [CW-1:0]     inflight_count,
    output logic              resolve_error
);

    typedef struct packed {
        logic [HIST_W-1:0] hist;
        logic              pred;
    } entry_t;

    entry_t head;
    entry_t push_data;
    logic   full;
    logic   empty;
    logic   do_resolve;
    logic   mispredict_now;
    logic   do_fetch;

    assign do_resolve     = resolve_valid && !empty;
    assign mispredict_now = do_resolve && (resolve_taken != head.pred);

    // Blocked on a repair cycle: the new fetch would use the wrong history.
    // A same-cycle pop does not free a slot while full.
    assign fetch_ready = !full && !mispredict_now;
    assign do_fetch    = fetch_valid && fetch_ready;

    assign push_data.hist = global_history;
    assign push_data.pred = fetch_taken_pred;

    ghr_checkpoint_fifo #(
        .entry_t (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (do_fetch),
        .push_data (push_data),
        .pop       (do_resolve && !mispredict_now),
        .flush     (mispredict_now),
        .head_data (head),
        .count     (inflight_count),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            global_history  <= '0;
            retired_history <= '0;
        end else begin
            if (mispredict_now) begin
                global_history <= {head.hist[HIST_W-2:0], resolve_taken};
            end else if (do_fetch) begin
                global_history <= {global_history[HIST_W-2:0], fetch_taken_pred};
            end
            if (do_resolve) begin
                retired_history <= {retired_history[HIST_W-2:0], resolve_taken};
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            upd_valid      <= 1'b0;
            upd_history    <= '0;
            upd_taken      <= 1'b0;
            upd_mispredict <= 1'b0;
            resolve_error  <= 1'b0;
        end else begin
            upd_valid     <= do_resolve;
            resolve_error <= resolve_valid && empty;
            if (do_resolve) begin
                upd_history    <= head.hist;
                upd_taken      <= resolve_taken;
                upd_mispredict <= mispredict_now;
            end
        end
    end

endmodule

// File: tb/tb_global_history_register.sv
// Directed self-checking bench for global_history_register.
// Expected values are hand-computed for HIST_W=12, DEPTH=8.
module tb_global_history_register;

    logic        clock;
    logic        reset;
    logic        fetch_valid;
    logic        fetch_taken_pred;
    logic        fetch_ready;
    logic [11:0] global_history;
    logic        resolve_valid;
    logic        resolve_taken;
    logic        upd_valid;
    logic [11:0] upd_history;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [11:0] retired_history;
    logic [3:0]  inflight_count;
    logic        resolve_error;

    int checks;
    int passed;

    global_history_register #(
        .HIST_W (12),
        .DEPTH  (8)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .fetch_valid      (fetch_valid),
        .fetch_taken_pred (fetch_taken_pred),
        .fetch_ready      (fetch_ready),
        .global_history   (global_history),
        .resolve_valid    (resolve_valid),
        .resolve_taken    (resolve_taken),
        .upd_valid        (upd_valid),
        .upd_history      (upd_history),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .retired_history  (retired_history),
        .inflight_count   (inflight_count),
        .resolve_error    (resolve_error)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int fill_bits [8];
    int wrap_hist [8];
    int wrap_pred [8];

    initial begin
        checks = 0;
        passed = 0;
        fill_bits = '{1, 0, 1, 1, 0, 0, 1, 0};
        wrap_hist = '{'h001, 'h002, 'h005, 'h00b, 'h016, 'h02c, 'h059, 'h0b2};
        wrap_pred = '{0, 1, 1, 0, 0, 1, 0, 1};

        reset = 1'b1;
        fetch_valid = 1'b0;
        fetch_taken_pred = 1'b0;
        resolve_valid = 1'b0;
        resolve_taken = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst_gh", 32'(global_history), 32'h0);
        chk("rst_ret", 32'(retired_history), 32'h0);
        chk("rst_cnt", 32'(inflight_count), 32'h0);
        chk("rst_upd", 32'(upd_valid), 32'h0);
        chk("rst_err", 32'(resolve_error), 32'h0);
        chk("rst_rdy", 32'(fetch_ready), 32'h1);

        // Fetch T,T,N
        fetch_valid = 1'b1;
        fetch_taken_pred = 1'b1;
        tick();
        chk("f1_gh", 32'(global_history), 32'h001);
        tick();
        chk("f2_gh", 32'(global_history), 32'h003);
        fetch_taken_pred = 1'b0;
        tick();
        chk("f3_gh", 32'(global_history), 32'h006);
        fetch_valid = 1'b0;
        chk("f3_cnt", 32'(inflight_count), 32'd3);

        // Resolve all three correctly
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        tick();
        chk("r1_uv", 32'(upd_valid), 32'h1);
        chk("r1_uh", 32'(upd_history), 32'h000);
        chk("r1_ut", 32'(upd_taken), 32'h1);
        chk("r1_um", 32'(upd_mispredict), 32'h0);
        tick();
        chk("r2_uh", 32'(upd_history), 32'h001);
        resolve_taken = 1'b0;
        tick();
        chk("r3_uh", 32'(upd_history), 32'h003);
        chk("r3_ut", 32'(upd_taken), 32'h0);
        chk("r3_um", 32'(upd_mispredict), 32'h0);
        chk("r3_ret", 32'(retired_history), 32'h006);
        chk("r3_cnt", 32'(inflight_count), 32'd0);
        resolve_valid = 1'b0;
        tick();
        chk("r_idle_uv", 32'(upd_valid), 32'h0);

        // Fresh start, fetch T,T,T then mispredict the first
        reset = 1'b1;
        tick();
        reset = 1'b0;
        fetch_valid = 1'b1;
        fetch_taken_pred = 1'b1;
        tick();
        tick();
        tick();
        chk("m_gh7", 32'(global_history), 32'h007);
        resolve_valid = 1'b1;
        resolve_taken = 1'b0;
        #1;
        chk("m_rdy_low", 32'(fetch_ready), 32'h0);
        tick();
        resolve_valid = 1'b0;
        fetch_valid = 1'b0;
        chk("m_um", 32'(upd_mispredict), 32'h1);
        chk("m_uh", 32'(upd_history), 32'h000);
        chk("m_gh", 32'(global_history), 32'h000);
        chk("m_cnt", 32'(inflight_count), 32'd0);
        chk("m_ret", 32'(retired_history), 32'h000);
        #1;
        chk("m_rdy_back", 32'(fetch_ready), 32'h1);

        // Fill all 8 slots
        fetch_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            fetch_taken_pred = fill_bits[i][0];
            tick();
        end
        fetch_valid = 1'b0;
        #1;
        chk("full_gh", 32'(global_history), 32'h0b2);
        chk("full_cnt", 32'(inflight_count), 32'd8);
        chk("full_rdy", 32'(fetch_ready), 32'h0);

        // Correct resolve plus fetch while full: pop only
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        fetch_valid = 1'b1;
        fetch_taken_pred = 1'b1;
        #1;
        chk("full_pop_rdy", 32'(fetch_ready), 32'h0);
        tick();
        resolve_valid = 1'b0;
        chk("pop_cnt", 32'(inflight_count), 32'd7);
        chk("pop_uh", 32'(upd_history), 32'h000);
        chk("pop_gh", 32'(global_history), 32'h0b2);
        #1;
        chk("pop_rdy", 32'(fetch_ready), 32'h1);
        tick();
        fetch_valid = 1'b0;
        chk("wrap_cnt", 32'(inflight_count), 32'd8);
        chk("wrap_gh", 32'(global_history), 32'h165);

        // Drain across the pointer wrap, all correct
        resolve_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            resolve_taken = wrap_pred[i][0];
            tick();
            chk("drain_uh", 32'(upd_history), 32'(wrap_hist[i]));
            chk("drain_um", 32'(upd_mispredict), 32'h0);
        end
        resolve_valid = 1'b0;
        chk("drain_cnt", 32'(inflight_count), 32'd0);
        chk("drain_ret", 32'(retired_history), 32'h165);

        // Resolve with nothing in flight
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        tick();
        resolve_valid = 1'b0;
        chk("err_pulse", 32'(resolve_error), 32'h1);
        chk("err_uv", 32'(upd_valid), 32'h0);
        chk("err_gh", 32'(global_history), 32'h165);
        chk("err_ret", 32'(retired_history), 32'h165);
        tick();
        chk("err_clear", 32'(resolve_error), 32'h0);

        // Reset with 5 in flight and a resolve pending
        fetch_valid = 1'b1;
        fetch_taken_pred = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        chk("pre_rst_cnt", 32'(inflight_count), 32'd5);
        chk("pre_rst_gh", 32'(global_history), 32'hca0);
        resolve_valid = 1'b1;
        resolve_taken = 1'b1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        resolve_valid = 1'b0;
        fetch_valid = 1'b0;
        chk("mrst_gh", 32'(global_history), 32'h0);
        chk("mrst_ret", 32'(retired_history), 32'h0);
        chk("mrst_cnt", 32'(inflight_count), 32'd0);
        chk("mrst_uv", 32'(upd_valid), 32'h0);
        chk("mrst_uh", 32'(upd_history), 32'h0);
        chk("mrst_um", 32'(upd_mispredict), 32'h0);
        chk("mrst_ut", 32'(upd_taken), 32'h0);
        chk("mrst_err", 32'(resolve_error), 32'h0);
        #1;
        chk("mrst_rdy", 32'(fetch_ready), 32'h1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
